// File: rtl/hdmi_frame_fetch.sv
// rtl/hdmi_frame_fetch.sv - HDMI raster timing generator with DDR line-fetch address sequencer
module hdmi_frame_fetch #(
   parameter int HFP = 110,
   parameter int HSW = 40,
   parameter int HBP = 220,
   parameter int VFP = 5,
   parameter int VSW = 5,
   parameter int VBP = 20
) (
   input  logic        Bus2IP_Clk,
   input  logic        Bus2IP_Resetn,
   input  logic        start_video,
   input  logic        start_fetch,
   input  logic [10:0] hres,
   input  logic [9:0]  vres,
   input  logic [31:0] color,
   input  logic [31:0] FRAME_BASE_ADDR,
   input  logic [31:0] LINE_STRIDE,
   input  logic [31:0] NUM_BYTES_PER_PIXEL,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        ve,
   output logic        read_go,
   output logic        read_next_line,
   output logic        read_next_chunk,
   output logic        read_done,
   output logic [31:0] ddr_addr_to_read,
   output logic        go_fill_fifo
);

   typedef enum logic {T_IDLE, T_RUN} tstate_t;
   typedef enum logic {F_IDLE, F_FETCH} fstate_t;

   tstate_t     tstate_q;
   fstate_t     fstate_q;
   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] vcnt_q, vcnt_d;
   logic [31:0] addr_q;
   logic        go_q;

   logic [11:0] hres_w, vres_w, htotal, vtotal, hs_lo, vs_lo, half;
   logic        run, hend, vend, line_end, arm;
   logic [31:0] step;
   logic        unused_color;

   assign hres_w = {1'b0, hres};
   assign vres_w = {2'b0, vres};
   assign htotal = hres_w + 12'(HFP + HSW + HBP);
   assign vtotal = vres_w + 12'(VFP + VSW + VBP);
   assign hs_lo  = hres_w + 12'(HFP);
   assign vs_lo  = vres_w + 12'(VFP);
   assign half   = {1'b0, hres_w[11:1]};
   assign step   = LINE_STRIDE * NUM_BYTES_PER_PIXEL;

   assign run  = (tstate_q == T_RUN);
   assign hend = (hcnt_q == htotal - 12'd1);
   assign vend = (vcnt_q == vtotal - 12'd1);

   assign hcnt_d = hend ? 12'd0 : hcnt_q + 12'd1;
   assign vcnt_d = hend ? (vend ? 12'd0 : vcnt_q + 12'd1) : vcnt_q;

   // Compares use +1 on the counter side so hres/vres of 0 never match an underflowed limit
   assign line_end        = run && (hcnt_q + 12'd1 == hres_w);
   assign ve              = run && (hcnt_q < hres_w) && (vcnt_q < vres_w);
   assign hsync           = run && (hcnt_q >= hs_lo) && (hcnt_q < hs_lo + 12'(HSW));
   assign vsync           = run && (vcnt_q >= vs_lo) && (vcnt_q < vs_lo + 12'(VSW));
   assign read_next_line  = line_end && (vcnt_q + 12'd1 < vres_w);
   assign read_done       = line_end && (vcnt_q + 12'd1 == vres_w);
   assign read_next_chunk = run && (hcnt_q + 12'd1 == half) && (vcnt_q < vres_w);
   assign read_go         = (!run && start_video && Bus2IP_Resetn) || (run && hend && vend);

   assign red   = ve ? color[23:16] : 8'h00;
   assign green = ve ? color[15:8]  : 8'h00;
   assign blue  = ve ? color[7:0]   : 8'h00;
   assign unused_color = ^color[31:24];

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn) begin
         tstate_q <= T_IDLE;
         hcnt_q   <= 12'd0;
         vcnt_q   <= 12'd0;
      end else begin
         case (tstate_q)
            T_IDLE: begin
               hcnt_q <= 12'd0;
               vcnt_q <= 12'd0;
               if (start_video) tstate_q <= T_RUN;
            end
            default: begin
               hcnt_q <= hcnt_d;
               vcnt_q <= vcnt_d;
            end
         endcase
      end
   end

   assign arm = start_fetch | read_go;

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn) begin
         fstate_q <= F_IDLE;
         addr_q   <= 32'd0;
         go_q     <= 1'b0;
      end else begin
         go_q <= 1'b0;
         case (fstate_q)
            F_IDLE: begin
               if (arm) begin
                  fstate_q <= F_FETCH;
                  addr_q   <= FRAME_BASE_ADDR;
                  go_q     <= 1'b1;
               end
            end
            default: begin
               if (arm) begin
                  addr_q <= FRAME_BASE_ADDR;
                  go_q   <= 1'b1;
               end else if (read_done) begin
                  addr_q   <= FRAME_BASE_ADDR;
                  fstate_q <= F_IDLE;
               end else if (read_next_line) begin
                  addr_q <= addr_q + step;
                  go_q   <= 1'b1;
               end
            end
         endcase
      end
   end

   assign ddr_addr_to_read = addr_q;
   assign go_fill_fifo     = go_q;

endmodule

// File: tb/tb_hdmi_frame_fetch.sv
// tb/tb_hdmi_frame_fetch.sv - directed self-checking bench for hdmi_frame_fetch
module tb_hdmi_frame_fetch;

   logic        clk = 1'b0;
   logic        resetn, start_video, start_fetch;
   logic [10:0] hres;
   logic [9:0]  vres;
   logic [31:0] color, base, stride, bpp;
   logic [7:0]  red, green, blue;
   logic        hsync, vsync, ve, read_go, read_next_line, read_next_chunk, read_done;
   logic [31:0] ddr_addr_to_read;
   logic        go_fill_fifo;

   int pass_cnt = 0;
   int total    = 0;

   hdmi_frame_fetch dut (
      .Bus2IP_Clk(clk), .Bus2IP_Resetn(resetn), .start_video(start_video),
      .start_fetch(start_fetch), .hres(hres), .vres(vres), .color(color),
      .FRAME_BASE_ADDR(base), .LINE_STRIDE(stride), .NUM_BYTES_PER_PIXEL(bpp),
      .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .ve(ve),
      .read_go(read_go), .read_next_line(read_next_line), .read_next_chunk(read_next_chunk),
      .read_done(read_done), .ddr_addr_to_read(ddr_addr_to_read), .go_fill_fifo(go_fill_fifo)
   );

   always #5 clk = ~clk;

   logic [34:0] outs;
   assign outs = {red, green, blue, hsync, vsync, ve, read_go,
                  read_next_line, read_next_chunk, read_done, go_fill_fifo};

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   int n;
   int c_ve, c_hs, c_vs, c_rnl, c_rnc, c_rd, c_rg, c_go;
   int first_vs, last_vs, first_hs;

   initial begin
      resetn = 1'b0; start_video = 1'b1; start_fetch = 1'b0;
      hres = 11'd8; vres = 10'd4;
      color = 32'h00FF00AA; base = 32'hA8000000; stride = 32'd1280; bpp = 32'd4;

      tick(2);
      chk("reset_outputs", 64'(outs), 64'd0);
      chk("reset_addr", ddr_addr_to_read, 32'd0);

      resetn = 1'b1;
      #1;
      chk("release_read_go", read_go, 1'b1);
      chk("release_ve", ve, 1'b0);

      tick();
      start_video = 1'b0;
      chk("run_ve_h0", ve, 1'b1);
      chk("run_rgb", {red, green, blue}, 24'hFF00AA);
      chk("run_read_go_once", read_go, 1'b0);
      chk("arm_go", go_fill_fifo, 1'b1);
      chk("arm_addr", ddr_addr_to_read, 32'hA8000000);

      tick();
      chk("go_one_cycle", go_fill_fifo, 1'b0);
      tick(2);
      chk("chunk_h3", read_next_chunk, 1'b1);
      tick();
      chk("chunk_h4", read_next_chunk, 1'b0);
      tick(3);
      chk("next_line_h7", read_next_line, 1'b1);
      chk("done_h7_line0", read_done, 1'b0);
      chk("ve_h7", ve, 1'b1);
      tick();
      chk("ve_h8", ve, 1'b0);
      chk("rgb_blank", {red, green, blue}, 24'h0);
      chk("line_step_addr", ddr_addr_to_read, 32'hA8001400);
      chk("line_step_go", go_fill_fifo, 1'b1);
      tick(109);
      chk("hsync_h117", hsync, 1'b0);
      tick();
      chk("hsync_h118", hsync, 1'b1);
      tick(39);
      chk("hsync_h157", hsync, 1'b1);
      tick();
      chk("hsync_h158", hsync, 1'b0);

      n = 0;
      while (!read_go && n < 20000) begin
         tick();
         n++;
      end
      chk("eof_read_go_seen", read_go, 1'b1);
      chk("eof_addr_idle", ddr_addr_to_read, 32'hA8000000);
      chk("eof_go_low", go_fill_fifo, 1'b0);

      c_ve = 0; c_hs = 0; c_vs = 0; c_rnl = 0; c_rnc = 0; c_rd = 0; c_rg = 0; c_go = 0;
      first_vs = -1; last_vs = -1; first_hs = -1;
      for (int i = 0; i < 12852; i++) begin
         tick();
         if (i == 0) begin
            chk("frame_start_go", go_fill_fifo, 1'b1);
            chk("frame_start_ve", ve, 1'b1);
         end
         c_ve += int'(ve); c_hs += int'(hsync); c_vs += int'(vsync);
         c_rnl += int'(read_next_line); c_rnc += int'(read_next_chunk);
         c_rd += int'(read_done); c_rg += int'(read_go); c_go += int'(go_fill_fifo);
         if (vsync) begin
            if (first_vs < 0) first_vs = i;
            last_vs = i;
         end
         if (hsync && first_hs < 0) first_hs = i;
      end
      chk("cnt_ve", c_ve, 32);
      chk("cnt_hsync", c_hs, 1360);
      chk("cnt_vsync", c_vs, 1890);
      chk("cnt_next_line", c_rnl, 3);
      chk("cnt_next_chunk", c_rnc, 4);
      chk("cnt_read_done", c_rd, 1);
      chk("cnt_read_go", c_rg, 1);
      chk("cnt_go", c_go, 4);
      chk("vsync_first", first_vs, 3402);
      chk("vsync_last", last_vs, 5291);
      chk("hsync_first", first_hs, 118);
      chk("frame_end_read_go", read_go, 1'b1);

      tick();
      chk("rearm_go", go_fill_fifo, 1'b1);
      chk("rearm_addr", ddr_addr_to_read, 32'hA8000000);

      base = 32'hFFFFF000;
      start_fetch = 1'b1;
      tick();
      start_fetch = 1'b0;
      chk("restart_addr", ddr_addr_to_read, 32'hFFFFF000);
      chk("restart_go", go_fill_fifo, 1'b1);
      tick(7);
      chk("wrap_addr", ddr_addr_to_read, 32'h00000400);
      chk("wrap_go", go_fill_fifo, 1'b1);

      resetn = 1'b0;
      tick();
      chk("midrun_reset_outputs", 64'(outs), 64'd0);
      chk("midrun_reset_addr", ddr_addr_to_read, 32'd0);
      resetn = 1'b1;
      tick(3);
      chk("idle_no_video", {ve, hsync, vsync, read_go}, 4'd0);
      base = 32'h12340000;
      start_fetch = 1'b1;
      tick();
      start_fetch = 1'b0;
      chk("idle_arm_addr", ddr_addr_to_read, 32'h12340000);
      chk("idle_arm_go", go_fill_fifo, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/hdmi_frame_fetch.md
Name: hdmi_frame_fetch

Overview:
- Combines a 720p-class HDMI raster timing generator with a DDR line-fetch address sequencer.
- The timing side produces hsync, vsync and the video-enable (ve) signal, and splits a 32-bit FIFO word into RGB.
- It also emits fetch-control pulses. The fetch side converts those pulses into a DDR read address plus a one-cycle go request.
- go_fill_fifo drives the master burst-read logic that fills the pixel FIFO. ve pops that FIFO.

Parameters:
- HFP, 110, horizontal front porch in pixels
- HSW, 40, hsync width in pixels
- HBP, 220, horizontal back porch in pixels
- VFP, 5, vertical front porch in lines
- VSW, 5, vsync width in lines
- VBP, 20, vertical back porch in lines

Ports:
- Bus2IP_Clk  in  1  single clock for the bus side and the pixel side
- Bus2IP_Resetn  in  1  synchronous, active-low reset
- start_video  in  1  level; starts the raster
- start_fetch  in  1  level; arms the fetcher (ORed with internal read_go)
- hres  in  11  active pixels per line
- vres  in  10  active lines per frame
- color  in  32  FIFO output word
- FRAME_BASE_ADDR  in  32  frame buffer base byte address
- LINE_STRIDE  in  32  pixels per line stride
- NUM_BYTES_PER_PIXEL  in  32  bytes per pixel
- red, green, blue  out  8 each  color[23:16], color[15:8], color[7:0]; forced to 0 when ve=0
- hsync, vsync  out  1  active-high sync pulses
- ve  out  1  active video; also the FIFO read enable
- read_go, read_next_line, read_next_chunk, read_done  out  1 each  one-cycle fetch pulses
- ddr_addr_to_read  out  32  current line address
- go_fill_fifo  out  1  one-cycle fetch request

Behaviour:
- Reset: all registers clear while Bus2IP_Resetn=0 at a clock edge, whatever the state. All outputs are 0, ddr_addr_to_read is 0, and both FSMs go to IDLE.
- Timing FSM states:
  - IDLE → RUN on the first edge with start_video=1. hcnt and vcnt are 0 on entering RUN.
  - RUN stays in RUN regardless of start_video; only reset leaves it.
- Counters:
  - HTOTAL = hres+HFP+HSW+HBP; VTOTAL = vres+VFP+VSW+VBP.
  - hcnt wraps at HTOTAL-1; vcnt increments on each hcnt wrap and wraps at VTOTAL-1.
  - Defaults give 1650×750.
- Timing decodes (combinational from the registered counters, valid only in RUN):
  - ve = hcnt<hres && vcnt<vres.
  - hsync = hres+HFP ≤ hcnt < hres+HFP+HSW.
  - vsync = vres+VFP ≤ vcnt < vres+VFP+VSW, for the whole line.
- Fetch pulses (each exactly one cycle):
  - read_go: in the IDLE cycle where start_video=1, and when hcnt=HTOTAL-1 and vcnt=VTOTAL-1 (next-frame prefetch).
  - read_next_line: hcnt=hres-1 and vcnt<vres-1.
  - read_next_chunk: hcnt=hres/2-1 (integer division) and vcnt<vres.
  - read_done: hcnt=hres-1 and vcnt=vres-1.
- Fetch FSM, with arm = start_fetch|read_go and priority reset > arm > read_done > read_next_line:
  - IDLE + arm → FETCH: ddr_addr_to_read ← FRAME_BASE_ADDR, go_fill_fifo=1 on the next cycle.
  - FETCH + arm: reload the base address and pulse go again (restart).
  - FETCH + read_next_line: addr ← addr + LINE_STRIDE*NUM_BYTES_PER_PIXEL, keeping the low 32 bits (wraps mod 2^32). go_fill_fifo pulses in the cycle after the address update, together with the new address.
  - FETCH + read_done: addr ← FRAME_BASE_ADDR, go stays 0, → IDLE.
  - IDLE ignores read_next_line and read_done.
- Latency: the go pulse comes 1 cycle after its trigger. ve gives no extra latency relative to color (color is consumed in the same cycle).
- Register inputs (base, stride, bpp) are sampled at the moment of use; changes take effect at the next arm or line step.

Test Plan:
- Reset held low for 2 cycles while start_video=1 → all outputs 0, counters frozen; releasing reset with start_video=1 → read_go pulses once, then ve rises with hcnt=0.
- Default parameters, hres=1280, vres=720 → ve high for 1280 cycles per line, hsync high from cycle 1390 to 1429 of each line, line period 1650, vsync high on lines 725–729, frame period 1,237,500 cycles.
- start_fetch pulse with base=0xA8000000, stride=1280, bpp=4 → next cycle addr=0xA8000000 and go_fill_fifo=1 for 1 cycle; after line 0's read_next_line → addr=0xA8001400 with one go pulse.
- Full frame → exactly 719 read_next_line, 720 read_next_chunk and 1 read_done. After read_done the fetcher is IDLE with addr=0xA8000000, and the end-of-frame read_go re-arms it with a go pulse.
- base=0xFFFFF000, stride=1280, bpp=4 → after one line step addr=0x00000400 (wrap).
- color=0x00FF00AA while ve=1 → red=0xFF, green=0x00, blue=0xAA; with ve=0 → all 0.
